uart_rx_edge_sampler: RTL
=========================

UART_RX_EDGE_SAMPLER -- requirements
Module: uart_rx_edge_sampler

Interface
REQ-001 Clock and reset: one clock, CLK; reset RST is asynchronous and active-low.
REQ-002 CLK  input  1  receiver oversampling clock.
REQ-003 RST  input  1  asynchronous active-low reset.
REQ-004 RX_IN  input  1  serial line, already synchronous to CLK; idle high.
REQ-005 enable  input  1  from the receive FSM; 1 = frame in progress, counters run.
REQ-006 dat_samp_en  input  1  from the receive FSM; 1 = sampling permitted.
REQ-007 PAR_EN  input  1  1 = frame carries a parity bit.
REQ-008 Prescale  input  6  oversampling ratio; legal values are 8, 16 and 32.
REQ-009 edge_cnt  output  6  oversample position within the current bit, 0..Prescale-1.
REQ-010 bit_cnt  output  4  bit index within the frame; 0 = start bit.
REQ-011 sampled_bit  output  1  decided value of the current bit.
REQ-012 samp_valid  output  1  one-cycle pulse when sampled_bit is updated.

Function
REQ-013 When enable=1, edge_cnt SHALL increment by 1 each cycle, wrapping from Prescale-1 to 0.
REQ-014 On each edge_cnt wrap, bit_cnt SHALL increment, wrapping to 0 from LAST, where LAST = 10 when PAR_EN=1 and 9 when PAR_EN=0.
REQ-015 When enable=0, edge_cnt and bit_cnt SHALL both be 0 on the next edge, whatever their current value (abort mid-frame).
REQ-016 Sample points SHALL be the cycles in which edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1, taken only when dat_samp_en=1 and enable=1.
REQ-017 sampled_bit SHALL update on the clock edge that ends the cycle with edge_cnt = Prescale/2+1; it is therefore valid from edge_cnt = Prescale/2+2 onward.
REQ-018 Hold rule: sampled_bit is stable at edge_cnt = Prescale/2+3, the FSM check point, and SHALL hold its value until the next update.
REQ-019 samp_valid SHALL be 1 for exactly the cycle following each sampled_bit update, once per bit, and 0 at all other times.
REQ-020 If dat_samp_en=0 at a sample point, that sample SHALL be ignored, no update SHALL occur for that bit, and samp_valid SHALL stay 0.
REQ-021 Width rule: Prescale/2+1 is computed in 6 bits; for Prescale=32 the maximum value is 17, with no overflow.
REQ-022 Prescale SHALL only change while enable=0; the block is not required to tolerate a change mid-frame.
REQ-023 The transition from enable=0 to enable=1 SHALL start counting at edge_cnt=0, bit_cnt=0 in the cycle enable is first seen high.

Reset
REQ-024 While RST=0, the outputs SHALL be edge_cnt=0, bit_cnt=0, sampled_bit=1, samp_valid=0, and the internal sample register SHALL be 3'b111.
REQ-025 RST asserted mid-frame SHALL clear all state immediately (asynchronously); after RST releases, operation resumes from the REQ-023 behaviour.

Configuration
REQ-026 Macro UART_RX_MAJORITY_EN, when defined, SHALL set sampled_bit to the 2-of-3 majority of the three samples in REQ-016.
REQ-027 Without UART_RX_MAJORITY_EN, sampled_bit SHALL equal the single sample at edge_cnt = Prescale/2; update timing and samp_valid timing SHALL be identical to REQ-017 and REQ-019.

Verification
REQ-028 Prescale=8, PAR_EN=0, enable held 1 for 80 cycles -> edge_cnt runs 0..7; bit_cnt runs 0..9 then returns to 0 at cycle 80.
REQ-029 Prescale=16, PAR_EN=1, RX_IN=0 only at edge_cnt=8 within a high bit -> with the macro, sampled_bit=1 and samp_valid pulses at edge_cnt=10; without the macro, sampled_bit=0.
REQ-030 Prescale=32, frame 0x5A sent LSB-first with the start bit -> the sampled_bit sequence at each samp_valid is 0,0,1,0,1,1,0,1,0,1; each update occurs with edge_cnt=18.
REQ-031 enable dropped at bit_cnt=4, edge_cnt=5 -> both counters are 0 the next cycle, and samp_valid does not pulse.
REQ-032 RST pulsed low at bit_cnt=6 -> all outputs immediately take their REQ-024 values, and the next frame counts from 0.
REQ-033 dat_samp_en=0 throughout bit 3 -> no samp_valid for bit 3, and sampled_bit keeps its bit-2 value.

Source files
------------

// File: rtl/uart_rx_edge_sampler_if.sv
// Signal bundle between the receive FSM and the UART RX edge/bit counter and sampler.
// The FSM side uses the master modport, and uart_rx_edge_sampler uses the slave modport.
interface uart_rx_edge_sampler_if;
  logic       RX_IN;
  logic       enable;
  logic       dat_samp_en;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       samp_valid;

  modport master (
    output RX_IN, enable, dat_samp_en, PAR_EN, Prescale,
    input  edge_cnt, bit_cnt, sampled_bit, samp_valid
  );

  modport slave (
    input  RX_IN, enable, dat_samp_en, PAR_EN, Prescale,
    output edge_cnt, bit_cnt, sampled_bit, samp_valid
  );
endinterface

// File: rtl/uart_rx_edge_sampler.sv
// UART RX oversample edge/bit counters plus a mid-bit sampler (three samples around Prescale/2).
// Define UART_RX_MAJORITY_EN for a 2-of-3 majority decision; otherwise the centre sample is used.
module uart_rx_edge_sampler (
  input  logic                   CLK,
  input  logic                   RST,
  uart_rx_edge_sampler_if.slave  bus
);
  localparam int unsigned CNT_W = 6;
  localparam int unsigned BIT_W = 4;

`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJORITY = 1'b1;
`else
  localparam bit MAJORITY = 1'b0;
`endif

  logic [CNT_W-1:0] edge_q;
  logic [BIT_W-1:0] bit_q;
  logic [2:0]       samp_q;
  logic             samp_ok_q;
  logic             sampled_q;
  logic             valid_q;

  logic [CNT_W-1:0] half_c;
  logic [CNT_W-1:0] samp_lo_c;
  logic [CNT_W-1:0] samp_hi_c;
  logic [CNT_W-1:0] edge_last_c;
  logic [BIT_W-1:0] bit_last_c;
  logic             take_c;
  logic [2:0]       win_c;
  logic             decided_c;

  // Sample-window positions and wrap limits; every term fits in 6 bits for Prescale <= 32
  always_comb begin
    half_c      = bus.Prescale >> 1;
    samp_lo_c   = half_c - CNT_W'(1);
    samp_hi_c   = half_c + CNT_W'(1);
    edge_last_c = bus.Prescale - CNT_W'(1);
    bit_last_c  = bus.PAR_EN ? BIT_W'(10) : BIT_W'(9);
    take_c      = bus.enable && bus.dat_samp_en;
  end

  // The third sample is used directly from the line, in the same cycle the decision is made
  always_comb begin
    win_c    = samp_q;
    win_c[2] = bus.RX_IN;
    decided_c = MAJORITY ? ((win_c[0] & win_c[1]) | (win_c[0] & win_c[2]) | (win_c[1] & win_c[2]))
                         : win_c[1];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (!bus.enable) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (edge_q == edge_last_c) begin
      edge_q <= '0;
      bit_q  <= (bit_q == bit_last_c) ? '0 : bit_q + BIT_W'(1);
    end else begin
      edge_q <= edge_q + CNT_W'(1);
    end
  end

  // samp_ok_q records that every sample point of this bit was permitted
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_q    <= 3'b111;
      samp_ok_q <= 1'b0;
      sampled_q <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (edge_q == samp_lo_c) begin
        samp_ok_q <= take_c;
        if (take_c) samp_q[0] <= bus.RX_IN;
      end else if (edge_q == half_c) begin
        samp_ok_q <= samp_ok_q & take_c;
        if (take_c) samp_q[1] <= bus.RX_IN;
      end else if ((edge_q == samp_hi_c) && take_c) begin
        samp_q[2] <= bus.RX_IN;
        if (samp_ok_q) begin
          sampled_q <= decided_c;
          valid_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.edge_cnt    = edge_q;
  assign bus.bit_cnt     = bit_q;
  assign bus.sampled_bit = sampled_q;
  assign bus.samp_valid  = valid_q;
endmodule
